// File: rtl/decode_queue_pkg.sv
// Shared RV32I decode definitions: opcodes, instruction codes/classes and the
// queue entry layout used by the decoder and the decode queue.
package decode_queue_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Code 0 is reserved for illegal encodings.
    typedef enum logic [5:0] {
        IC_NONE = 6'd0,
        IC_LUI, IC_AUIPC, IC_JAL, IC_JALR,
        IC_BEQ, IC_BNE, IC_BLT, IC_BGE, IC_BLTU, IC_BGEU,
        IC_LB, IC_LH, IC_LW, IC_LBU, IC_LHU,
        IC_SB, IC_SH, IC_SW,
        IC_ADDI, IC_SLTI, IC_SLTIU, IC_XORI, IC_ORI, IC_ANDI,
        IC_SLLI, IC_SRLI, IC_SRAI,
        IC_ADD, IC_SUB, IC_SLL, IC_SLT, IC_SLTU, IC_XOR, IC_SRL, IC_SRA, IC_OR, IC_AND,
        IC_FENCE, IC_ECALL, IC_EBREAK
    } inst_code_e;

    // Class 0 is reserved for illegal encodings.
    typedef enum logic [2:0] {
        IT_NONE = 3'd0,
        IT_ALU  = 3'd1,
        IT_LD   = 3'd2,
        IT_ST   = 3'd3,
        IT_BRC  = 3'd4,
        IT_JMP  = 3'd5
    } inst_type_e;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             rd_en;
        logic [XLEN-1:0]  imm;
        inst_code_e       code;
        inst_type_e       itype;
        logic             illegal;
    } entry_t;

endpackage

// File: rtl/decode_queue_decode.sv
// rv32i_decode: purely combinational RV32I decoder.
// Ports: inst_in (raw instruction) -> code/class/immediate/register fields,
// rd write enable and illegal flag (all *_c, combinational).
module rv32i_decode
    import decode_queue_pkg::*;
(
    input  logic [XLEN-1:0]  inst_in,
    output inst_code_e       code_c,
    output inst_type_e       itype_c,
    output logic [XLEN-1:0]  imm_c,
    output logic [REG_W-1:0] rd_c,
    output logic [REG_W-1:0] rs1_c,
    output logic [REG_W-1:0] rs2_c,
    output logic             rd_en_c,
    output logic             illegal_c
);

    logic [6:0]      opcode_c;
    logic [2:0]      funct3_c;
    logic [6:0]      funct7_c;
    logic [XLEN-1:0] imm_i_c;
    logic [XLEN-1:0] imm_s_c;
    logic [XLEN-1:0] imm_b_c;
    logic [XLEN-1:0] imm_u_c;
    logic [XLEN-1:0] imm_j_c;
    logic [XLEN-1:0] imm_sh_c;

    assign opcode_c = inst_in[6:0];
    assign funct3_c = inst_in[14:12];
    assign funct7_c = inst_in[31:25];
    assign rd_c     = inst_in[11:7];
    assign rs1_c    = inst_in[19:15];
    assign rs2_c    = inst_in[24:20];

    // Immediate formats, sign-extended from inst[31].
    assign imm_i_c  = {{20{inst_in[31]}}, inst_in[31:20]};
    assign imm_s_c  = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
    assign imm_b_c  = {{19{inst_in[31]}}, inst_in[31], inst_in[7], inst_in[30:25], inst_in[11:8], 1'b0};
    assign imm_u_c  = {inst_in[31:12], 12'b0};
    assign imm_j_c  = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12], inst_in[20], inst_in[30:21], 1'b0};
    assign imm_sh_c = {27'b0, inst_in[24:20]};

    // Code stays IC_NONE for any unlisted opcode/funct combination.
    always_comb begin
        code_c    = IC_NONE;
        itype_c   = IT_NONE;
        imm_c     = '0;
        illegal_c = 1'b0;
        rd_en_c   = 1'b0;
        case (opcode_c)
            OPC_LUI:   begin code_c = IC_LUI;   itype_c = IT_ALU; imm_c = imm_u_c; end
            OPC_AUIPC: begin code_c = IC_AUIPC; itype_c = IT_ALU; imm_c = imm_u_c; end
            OPC_JAL:   begin code_c = IC_JAL;   itype_c = IT_JMP; imm_c = imm_j_c; end
            OPC_JALR: begin
                itype_c = IT_JMP;
                imm_c   = imm_i_c;
                if (funct3_c == 3'b000) code_c = IC_JALR;
            end
            OPC_BRANCH: begin
                itype_c = IT_BRC;
                imm_c   = imm_b_c;
                case (funct3_c)
                    3'b000:  code_c = IC_BEQ;
                    3'b001:  code_c = IC_BNE;
                    3'b100:  code_c = IC_BLT;
                    3'b101:  code_c = IC_BGE;
                    3'b110:  code_c = IC_BLTU;
                    3'b111:  code_c = IC_BGEU;
                    default: code_c = IC_NONE;
                endcase
            end
            OPC_LOAD: begin
                itype_c = IT_LD;
                imm_c   = imm_i_c;
                case (funct3_c)
                    3'b000:  code_c = IC_LB;
                    3'b001:  code_c = IC_LH;
                    3'b010:  code_c = IC_LW;
                    3'b100:  code_c = IC_LBU;
                    3'b101:  code_c = IC_LHU;
                    default: code_c = IC_NONE;
                endcase
            end
            OPC_STORE: begin
                itype_c = IT_ST;
                imm_c   = imm_s_c;
                case (funct3_c)
                    3'b000:  code_c = IC_SB;
                    3'b001:  code_c = IC_SH;
                    3'b010:  code_c = IC_SW;
                    default: code_c = IC_NONE;
                endcase
            end
            OPC_OP_IMM: begin
                itype_c = IT_ALU;
                imm_c   = imm_i_c;
                case (funct3_c)
                    3'b000: code_c = IC_ADDI;
                    3'b010: code_c = IC_SLTI;
                    3'b011: code_c = IC_SLTIU;
                    3'b100: code_c = IC_XORI;
                    3'b110: code_c = IC_ORI;
                    3'b111: code_c = IC_ANDI;
                    3'b001: begin
                        imm_c = imm_sh_c;
                        if (funct7_c == F7_ZERO) code_c = IC_SLLI;
                    end
                    default: begin
                        imm_c = imm_sh_c;
                        if (funct7_c == F7_ZERO)     code_c = IC_SRLI;
                        else if (funct7_c == F7_ALT) code_c = IC_SRAI;
                    end
                endcase
            end
            OPC_OP: begin
                itype_c = IT_ALU;
                if (funct7_c == F7_ZERO) begin
                    case (funct3_c)
                        3'b000:  code_c = IC_ADD;
                        3'b001:  code_c = IC_SLL;
                        3'b010:  code_c = IC_SLT;
                        3'b011:  code_c = IC_SLTU;
                        3'b100:  code_c = IC_XOR;
                        3'b101:  code_c = IC_SRL;
                        3'b110:  code_c = IC_OR;
                        default: code_c = IC_AND;
                    endcase
                end else if (funct7_c == F7_ALT) begin
                    if (funct3_c == 3'b000)      code_c = IC_SUB;
                    else if (funct3_c == 3'b101) code_c = IC_SRA;
                end
            end
            OPC_FENCE: begin
                itype_c = IT_ALU;
                imm_c   = imm_i_c;
                if (funct3_c == 3'b000) code_c = IC_FENCE;
            end
            OPC_SYSTEM: begin
                itype_c = IT_ALU;
                imm_c   = imm_i_c;
                if (inst_in == 32'h0000_0073)      code_c = IC_ECALL;
                else if (inst_in == 32'h0010_0073) code_c = IC_EBREAK;
            end
            default: ;
        endcase

        // Illegal encodings carry no class, immediate or writeback.
        illegal_c = (code_c == IC_NONE);
        if (illegal_c) begin
            itype_c = IT_NONE;
            imm_c   = '0;
        end
        rd_en_c = !illegal_c && (itype_c != IT_ST) && (itype_c != IT_BRC) && (rd_c != '0);
    end

endmodule

// File: rtl/decode_queue.sv
// decode_queue: FIFO of decoded RV32I instructions between fetch and dispatch.
// Ports: clk_in/rst_n_in (async active-low), rdy_in global enable, flush_in,
// in_valid/in_ready/in_inst/in_pc push side, out_* head entry with
// out_valid/out_ready pop side, count occupancy.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [REG_W-1:0] out_rd,
    output logic [REG_W-1:0] out_rs1,
    output logic [REG_W-1:0] out_rs2,
    output logic             out_rd_en,
    output logic [XLEN-1:0]  out_imm,
    output logic [5:0]       out_inst_code,
    output logic [2:0]       out_inst_type,
    output logic             out_illegal,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    inst_code_e       dec_code_c;
    inst_type_e       dec_itype_c;
    logic [XLEN-1:0]  dec_imm_c;
    logic [REG_W-1:0] dec_rd_c;
    logic [REG_W-1:0] dec_rs1_c;
    logic [REG_W-1:0] dec_rs2_c;
    logic             dec_rd_en_c;
    logic             dec_illegal_c;

    entry_t           entry_c;
    entry_t           head_c;
    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_c;
    logic             pop_c;

    rv32i_decode u_decode (
        .inst_in   (in_inst),
        .code_c    (dec_code_c),
        .itype_c   (dec_itype_c),
        .imm_c     (dec_imm_c),
        .rd_c      (dec_rd_c),
        .rs1_c     (dec_rs1_c),
        .rs2_c     (dec_rs2_c),
        .rd_en_c   (dec_rd_en_c),
        .illegal_c (dec_illegal_c)
    );

    assign entry_c = '{pc: in_pc, rd: dec_rd_c, rs1: dec_rs1_c, rs2: dec_rs2_c,
                       rd_en: dec_rd_en_c, imm: dec_imm_c, code: dec_code_c,
                       itype: dec_itype_c, illegal: dec_illegal_c};

    // Flow control derives only from registered occupancy.
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push_c    = rdy_in && !flush_in && in_valid && in_ready;
    assign pop_c     = rdy_in && !flush_in && out_valid && out_ready;

    // Pointer and occupancy update; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (rdy_in && flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
            else if (pop_c && !push_c) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: it is only visible while out_valid=1.
    always_ff @(posedge clk_in) begin
        if (push_c) mem_q[wr_ptr_q] <= entry_c;
    end

    // Zero the outputs when empty so reset/flush read as all-zero.
    assign head_c = out_valid ? mem_q[rd_ptr_q] : '0;

    assign out_pc        = head_c.pc;
    assign out_rd        = head_c.rd;
    assign out_rs1       = head_c.rs1;
    assign out_rs2       = head_c.rs2;
    assign out_rd_en     = head_c.rd_en;
    assign out_imm       = head_c.imm;
    assign out_inst_code = head_c.code;
    assign out_inst_type = head_c.itype;
    assign out_illegal   = head_c.illegal;
    assign count         = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue (DEPTH=4): directed scenarios plus a
// randomized stream compared against a mask/match table reference model.
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                           F_U = 3'd4, F_J = 3'd5, F_SH = 3'd6;

    typedef struct packed {
        inst_code_e  code;
        logic [31:0] mask;
        logic [31:0] match;
        inst_type_e  t;
        logic [2:0]  fmt;
    } tbl_t;

    logic        clk_in, rst_n_in, rdy_in, flush_in, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_pc, out_imm;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic        out_rd_en, out_illegal;
    logic [5:0]  out_inst_code;
    logic [2:0]  out_inst_type, count;

    int checks = 0;
    int failures = 0;
    entry_t mq[$];

    decode_queue #(.DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd_en(out_rd_en), .out_imm(out_imm),
        .out_inst_code(out_inst_code), .out_inst_type(out_inst_type),
        .out_illegal(out_illegal), .count(count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // RV32I instruction table in mask/match form.
    function automatic tbl_t tbl(input int i);
        case (i)
            0:  return '{IC_LUI,    32'h7F,       32'h37,       IT_ALU, F_U};
            1:  return '{IC_AUIPC,  32'h7F,       32'h17,       IT_ALU, F_U};
            2:  return '{IC_JAL,    32'h7F,       32'h6F,       IT_JMP, F_J};
            3:  return '{IC_JALR,   32'h707F,     32'h67,       IT_JMP, F_I};
            4:  return '{IC_BEQ,    32'h707F,     32'h63,       IT_BRC, F_B};
            5:  return '{IC_BNE,    32'h707F,     32'h1063,     IT_BRC, F_B};
            6:  return '{IC_BLT,    32'h707F,     32'h4063,     IT_BRC, F_B};
            7:  return '{IC_BGE,    32'h707F,     32'h5063,     IT_BRC, F_B};
            8:  return '{IC_BLTU,   32'h707F,     32'h6063,     IT_BRC, F_B};
            9:  return '{IC_BGEU,   32'h707F,     32'h7063,     IT_BRC, F_B};
            10: return '{IC_LB,     32'h707F,     32'h03,       IT_LD,  F_I};
            11: return '{IC_LH,     32'h707F,     32'h1003,     IT_LD,  F_I};
            12: return '{IC_LW,     32'h707F,     32'h2003,     IT_LD,  F_I};
            13: return '{IC_LBU,    32'h707F,     32'h4003,     IT_LD,  F_I};
            14: return '{IC_LHU,    32'h707F,     32'h5003,     IT_LD,  F_I};
            15: return '{IC_SB,     32'h707F,     32'h23,       IT_ST,  F_S};
            16: return '{IC_SH,     32'h707F,     32'h1023,     IT_ST,  F_S};
            17: return '{IC_SW,     32'h707F,     32'h2023,     IT_ST,  F_S};
            18: return '{IC_ADDI,   32'h707F,     32'h13,       IT_ALU, F_I};
            19: return '{IC_SLTI,   32'h707F,     32'h2013,     IT_ALU, F_I};
            20: return '{IC_SLTIU,  32'h707F,     32'h3013,     IT_ALU, F_I};
            21: return '{IC_XORI,   32'h707F,     32'h4013,     IT_ALU, F_I};
            22: return '{IC_ORI,    32'h707F,     32'h6013,     IT_ALU, F_I};
            23: return '{IC_ANDI,   32'h707F,     32'h7013,     IT_ALU, F_I};
            24: return '{IC_SLLI,   32'hFE00707F, 32'h1013,     IT_ALU, F_SH};
            25: return '{IC_SRLI,   32'hFE00707F, 32'h5013,     IT_ALU, F_SH};
            26: return '{IC_SRAI,   32'hFE00707F, 32'h40005013, IT_ALU, F_SH};
            27: return '{IC_ADD,    32'hFE00707F, 32'h33,       IT_ALU, F_R};
            28: return '{IC_SUB,    32'hFE00707F, 32'h40000033, IT_ALU, F_R};
            29: return '{IC_SLL,    32'hFE00707F, 32'h1033,     IT_ALU, F_R};
            30: return '{IC_SLT,    32'hFE00707F, 32'h2033,     IT_ALU, F_R};
            31: return '{IC_SLTU,   32'hFE00707F, 32'h3033,     IT_ALU, F_R};
            32: return '{IC_XOR,    32'hFE00707F, 32'h4033,     IT_ALU, F_R};
            33: return '{IC_SRL,    32'hFE00707F, 32'h5033,     IT_ALU, F_R};
            34: return '{IC_SRA,    32'hFE00707F, 32'h40005033, IT_ALU, F_R};
            35: return '{IC_OR,     32'hFE00707F, 32'h6033,     IT_ALU, F_R};
            36: return '{IC_AND,    32'hFE00707F, 32'h7033,     IT_ALU, F_R};
            37: return '{IC_FENCE,  32'h707F,     32'h0F,       IT_ALU, F_I};
            38: return '{IC_ECALL,  32'hFFFFFFFF, 32'h73,       IT_ALU, F_I};
            default: return '{IC_EBREAK, 32'hFFFFFFFF, 32'h100073, IT_ALU, F_I};
        endcase
    endfunction

    // Reference decode: first table hit wins; no hit means illegal.
    function automatic entry_t ref_decode(input logic [31:0] pc, input logic [31:0] inst);
        entry_t e;
        tbl_t   r;
        logic [31:0] sx;
        e = '0;
        e.pc = pc; e.rd = inst[11:7]; e.rs1 = inst[19:15]; e.rs2 = inst[24:20];
        e.illegal = 1'b1;
        sx = inst[31] ? 32'hFFFFFFFF : 32'h0;
        for (int i = 0; i < 40; i++) begin
            r = tbl(i);
            if (e.illegal && ((inst & r.mask) == r.match)) begin
                e.illegal = 1'b0; e.code = r.code; e.itype = r.t;
                case (r.fmt)
                    F_I:  e.imm = (sx << 12) | 32'(inst[31:20]);
                    F_S:  e.imm = (sx << 12) | (32'(inst[31:25]) << 5) | 32'(inst[11:7]);
                    F_B:  e.imm = (sx << 12) | (32'(inst[7]) << 11) | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
                    F_U:  e.imm = inst & 32'hFFFFF000;
                    F_J:  e.imm = (sx << 20) | (32'(inst[19:12]) << 12) | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
                    F_SH: e.imm = 32'(inst[24:20]);
                    default: e.imm = 32'h0;
                endcase
            end
        end
        e.rd_en = !e.illegal && e.itype != IT_ST && e.itype != IT_BRC && e.rd != 5'd0;
        return e;
    endfunction

    task automatic test_reset();
        rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'h0; in_pc = 32'h0;
        #12;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if ({out_pc, out_imm, out_inst_code} !== '0) begin failures++; $display("FAIL rst_data got=%0h exp=0", {out_pc, out_imm, out_inst_code}); end
        @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    // First push right after reset release, no bypass.
    task automatic test_addi();
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h100;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL addi_bypass got=%0b exp=0", out_valid); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0b exp=1", out_valid); end
        checks++; if (out_inst_code !== IC_ADDI) begin failures++; $display("FAIL addi_code got=%0d exp=%0d", out_inst_code, IC_ADDI); end
        checks++; if (out_inst_type !== IT_ALU) begin failures++; $display("FAIL addi_type got=%0d exp=%0d", out_inst_type, IT_ALU); end
        checks++; if (out_rd !== 5'd1 || out_rd_en !== 1'b1) begin failures++; $display("FAIL addi_rd got=%0d/%0b exp=1/1", out_rd, out_rd_en); end
        checks++; if (out_imm !== 32'h5) begin failures++; $display("FAIL addi_imm got=%0h exp=5", out_imm); end
        checks++; if (out_pc !== 32'h100) begin failures++; $display("FAIL addi_pc got=%0h exp=100", out_pc); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL addi_pop got=%0d/%0b exp=0/0", count, out_valid); end
    endtask

    task automatic test_srai();
        in_valid = 1'b1; in_inst = 32'h40415193; in_pc = 32'h104; tick(); in_valid = 1'b0;
        checks++; if (out_inst_code !== IC_SRAI) begin failures++; $display("FAIL srai_code got=%0d exp=%0d", out_inst_code, IC_SRAI); end
        checks++; if (out_imm !== 32'h4) begin failures++; $display("FAIL srai_imm got=%0h exp=4", out_imm); end
        checks++; if (out_rs1 !== 5'd2 || out_rd !== 5'd3) begin failures++; $display("FAIL srai_regs got=%0d/%0d exp=2/3", out_rs1, out_rd); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_branch_illegal();
        in_valid = 1'b1; in_inst = 32'hFE000CE3; in_pc = 32'h200; tick();
        in_inst = 32'hFFFFFFFF; in_pc = 32'h204; tick(); in_valid = 1'b0;
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL brc_count got=%0d exp=2", count); end
        checks++; if (out_inst_type !== IT_BRC || out_inst_code !== IC_BEQ) begin failures++; $display("FAIL brc_class got=%0d/%0d exp=%0d/%0d", out_inst_type, out_inst_code, IT_BRC, IC_BEQ); end
        checks++; if (out_imm !== 32'hFFFFFFF8) begin failures++; $display("FAIL brc_imm got=%0h exp=fffffff8", out_imm); end
        checks++; if (out_rd_en !== 1'b0) begin failures++; $display("FAIL brc_rd_en got=%0b exp=0", out_rd_en); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (out_illegal !== 1'b1 || out_pc !== 32'h204) begin failures++; $display("FAIL ill_flag got=%0b/%0h exp=1/204", out_illegal, out_pc); end
        checks++; if ({out_inst_code, out_inst_type, out_imm, out_rd_en} !== '0) begin failures++; $display("FAIL ill_fields got=%0h exp=0", {out_inst_code, out_inst_type, out_imm, out_rd_en}); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h1000 + 32'(4 * k); tick();
        end
        checks++; if (in_ready !== 1'b0 || count !== 3'd4) begin failures++; $display("FAIL full_state got=%0b/%0d exp=0/4", in_ready, count); end
        in_pc = 32'h1010; tick();
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_hold got=%0d exp=4", count); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (count !== 3'd3 || in_ready !== 1'b1) begin failures++; $display("FAIL full_pop got=%0d/%0b exp=3/1", count, in_ready); end
        tick(); in_valid = 1'b0;
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_fifth got=%0d exp=4", count); end
        for (int k = 1; k < 5; k++) begin
            checks++; if (out_pc !== 32'h1000 + 32'(4 * k)) begin failures++; $display("FAIL full_order k=%0d got=%0h exp=%0h", k, out_pc, 32'h1000 + 32'(4 * k)); end
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL full_drain got=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h400 + 32'(4 * k); tick();
        end
        flush_in = 1'b1; out_ready = 1'b1; in_pc = 32'h40C; tick();
        flush_in = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_state got=%0d/%0b exp=0/0", count, out_valid); end
        tick();
        checks++; if (count !== 3'd0 || out_pc !== 32'h0) begin failures++; $display("FAIL flush_after got=%0d/%0h exp=0/0", count, out_pc); end
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_inst = 32'h00200113; in_pc = 32'h300; tick();
        rdy_in = 1'b0; flush_in = 1'b1; out_ready = 1'b1; in_pc = 32'h304; tick();
        checks++; if (count !== 3'd1 || out_pc !== 32'h300) begin failures++; $display("FAIL stall_hold got=%0d/%0h exp=1/300", count, out_pc); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_in_ready got=%0b exp=1", in_ready); end
        rdy_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0; tick(); out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL stall_resume got=%0d exp=0", count); end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_inst = 32'h00300193; in_pc = 32'h500; tick();
        in_pc = 32'h504; tick(); in_valid = 1'b0;
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL arst_pre got=%0d exp=2", count); end
        #2 rst_n_in = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL arst_ctrl got=%0b/%0d/%0b exp=0/0/1", out_valid, count, in_ready); end
        checks++; if ({out_pc, out_imm, out_rd, out_rd_en} !== '0) begin failures++; $display("FAIL arst_data got=%0h exp=0", {out_pc, out_imm, out_rd, out_rd_en}); end
        #1 rst_n_in = 1'b1;
        tick();
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL arst_post got=%0d/%0b exp=0/0", count, out_valid); end
    endtask

    task automatic test_random();
        entry_t exp_head, got;
        tbl_t   r;
        int     sel;
        logic [31:0] pc_ctr = 32'h8000;
        mq.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            exp_head = (mq.size() != 0) ? mq[0] : '0;
            got = '{out_pc, out_rd, out_rs1, out_rs2, out_rd_en, out_imm,
                    inst_code_e'(out_inst_code), inst_type_e'(out_inst_type), out_illegal};
            checks++; if (out_valid !== (mq.size() != 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, mq.size() != 0); end
            checks++; if (count !== 3'(mq.size())) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, count, mq.size()); end
            checks++; if (in_ready !== (mq.size() < DEPTH)) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, mq.size() < DEPTH); end
            checks++; if (got !== exp_head) begin failures++; $display("FAIL rnd_head cyc=%0d got=%h exp=%h", cyc, got, exp_head); end
            rdy_in    = ($urandom_range(0, 9) != 0);
            flush_in  = ($urandom_range(0, 24) == 0);
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 1) == 1);
            sel = int'($urandom_range(0, 43));
            if (sel >= 40) in_inst = $urandom;
            else begin
                r = tbl(sel);
                in_inst = ($urandom & ~r.mask) | r.match;
            end
            pc_ctr += 32'd4;
            in_pc = pc_ctr;
            @(posedge clk_in);
            if (rdy_in) begin
                if (flush_in) mq.delete();
                else begin
                    logic do_push, do_pop;
                    do_push = in_valid && (mq.size() < DEPTH);
                    do_pop  = out_ready && (mq.size() != 0);
                    if (do_pop) void'(mq.pop_front());
                    if (do_push) mq.push_back(ref_decode(in_pc, in_inst));
                end
            end
            #1;
        end
        rdy_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_srai();
        test_branch_illegal();
        test_full();
        test_flush();
        test_stall();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
